// File: rtl/xor_checksum_if.sv
// Handshake bundle for xor_checksum.
//   Input stream : in_valid, in_ready, in_data[WIDTH], in_last
//   Result port  : out_valid, out_ready, out_sum[WIDTH], out_parity,
//                  out_count[CW], out_ovf
// The master modport drives the stream and consumes results.
// The slave modport is the checksum block.
interface xor_checksum_if #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_parity;
  logic [CW-1:0]    out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_parity, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_parity, out_count, out_ovf
  );
endinterface

// File: rtl/xor_checksum.sv
// xor_checksum: folds a framed stream of words with XOR (or XNOR when
// INVERT=1) and presents one result per frame, together with the
// parity of that result, a saturating beat count and an overflow flag.
// Ports:
//   clk    - sole clock, rising edge
//   rst_n  - synchronous active-low reset
//   bus    - xor_checksum_if slave modport (input stream + result port)
// A frame's result is held in DONE until taken; no new word is accepted
// while a result is held, including the cycle in which it is taken.
module xor_checksum #(
  parameter int WIDTH  = 8,
  parameter int CW     = 4,
  parameter int INVERT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  xor_checksum_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic signed [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_take;
  logic [WIDTH-1:0] w_sum;

  // Beat counter sticks at its maximum instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  function automatic logic [WIDTH-1:0] fold_result(input logic [WIDTH-1:0] a);
    return (INVERT != 0) ? ~a : a;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE, ACCUM: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_nxt = bus.in_last ? DONE : ACCUM;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_take   = w_out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        // The first beat loads rather than folds, so a stale accumulator
        // can never leak into a new frame.
        if (r_state == IDLE) begin
          r_acc <= bus.in_data;
        end else begin
          r_acc <= r_acc ^ bus.in_data;
        end
        r_cnt <= sat_inc(r_cnt);
        if (r_cnt == CNT_MAX) begin
          r_ovf <= 1'b1;
        end
      end else if (w_take) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end
    end
  end

  // Result fields are forced to zero whenever no result is presented.
  assign w_sum          = w_out_valid ? fold_result(r_acc) : '0;
  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_sum    = w_sum;
  assign bus.out_parity = ^w_sum;
  assign bus.out_count  = w_out_valid ? r_cnt : '0;
  assign bus.out_ovf    = w_out_valid & r_ovf;

endmodule

// File: tb/tb_xor_checksum.sv
// Bench for xor_checksum: three instances (XOR/CW=4, XNOR/CW=4,
// XOR/CW=2) driven by a linear directed sequence; expected frame
// results are queued when a frame is sent and popped when presented.
module tb_xor_checksum;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xor_checksum_if #(.WIDTH(8), .CW(4)) if0 ();
  xor_checksum_if #(.WIDTH(8), .CW(4)) if1 ();
  xor_checksum_if #(.WIDTH(8), .CW(2)) if2 ();

  xor_checksum #(.WIDTH(8), .CW(4), .INVERT(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  xor_checksum #(.WIDTH(8), .CW(4), .INVERT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  xor_checksum #(.WIDTH(8), .CW(2), .INVERT(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  logic       tv_v [3];
  logic       tv_l [3];
  logic       tv_r [3];
  logic [7:0] tv_d [3];

  assign if0.in_valid = tv_v[0]; assign if0.in_last = tv_l[0];
  assign if0.in_data  = tv_d[0]; assign if0.out_ready = tv_r[0];
  assign if1.in_valid = tv_v[1]; assign if1.in_last = tv_l[1];
  assign if1.in_data  = tv_d[1]; assign if1.out_ready = tv_r[1];
  assign if2.in_valid = tv_v[2]; assign if2.in_last = tv_l[2];
  assign if2.in_data  = tv_d[2]; assign if2.out_ready = tv_r[2];

  typedef struct packed {
    logic       rdy;
    logic       vld;
    logic [7:0] sum;
    logic       par;
    logic [3:0] cnt;
    logic       ovf;
  } obs_t;

  typedef struct packed {
    logic [7:0] sum;
    logic       par;
    logic [3:0] cnt;
    logic       ovf;
  } res_t;

  res_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic obs_t sample(input int d);
    obs_t o;
    o = '0;
    case (d)
      0: o = '{if0.in_ready, if0.out_valid, if0.out_sum, if0.out_parity, if0.out_count, if0.out_ovf};
      1: o = '{if1.in_ready, if1.out_valid, if1.out_sum, if1.out_parity, if1.out_count, if1.out_ovf};
      default: o = '{if2.in_ready, if2.out_valid, if2.out_sum, if2.out_parity, {2'b00, if2.out_count}, if2.out_ovf};
    endcase
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs when no result is presented (also the reset values).
  task automatic chk_quiet(input int d, input string tag);
    obs_t o;
    o = sample(d);
    chk({tag, "_in_ready"}, o.rdy, 1);
    chk({tag, "_out_valid"}, o.vld, 0);
    chk({tag, "_out_sum"}, o.sum, 0);
    chk({tag, "_out_parity"}, o.par, 0);
    chk({tag, "_out_count"}, o.cnt, 0);
    chk({tag, "_out_ovf"}, o.ovf, 0);
  endtask

  // Offer one beat; it must be accepted at the next rising edge.
  task automatic send(input int d, input logic [7:0] dat, input logic last);
    tv_v[d] = 1'b1; tv_d[d] = dat; tv_l[d] = last;
    @(negedge clk);
    chk("beat_in_ready", sample(d).rdy, 1);
    @(posedge clk); #1;
    tv_v[d] = 1'b0; tv_l[d] = 1'b0; tv_d[d] = 8'h00;
  endtask

  // Called right after the last beat was accepted: the result must be
  // present in the very next cycle.
  task automatic expect_result(input int d, input string tag);
    obs_t o;
    res_t e;
    @(negedge clk);
    o = sample(d);
    chk({tag, "_out_valid"}, o.vld, 1);
    chk({tag, "_in_ready"}, o.rdy, 0);
    chk({tag, "_pending"}, (sb_q.size() != 0), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_out_sum"}, o.sum, e.sum);
      chk({tag, "_out_parity"}, o.par, e.par);
      chk({tag, "_out_count"}, o.cnt, e.cnt);
      chk({tag, "_out_ovf"}, o.ovf, e.ovf);
    end
  endtask

  initial begin
    obs_t o;
    for (int i = 0; i < 3; i++) begin
      tv_v[i] = 1'b0; tv_l[i] = 1'b0; tv_r[i] = 1'b0; tv_d[i] = 8'h00;
    end

    // Reset: held for two edges, outputs checked during and after.
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_quiet(0, "rst_during");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_quiet(0, "rst_after");
    @(posedge clk); #1;

    // Three-beat frame, taken immediately.
    tv_r[0] = 1'b1;
    send(0, 8'h5A, 1'b0);
    send(0, 8'hFF, 1'b0);
    sb_q.push_back('{8'hAA, 1'b0, 4'd3, 1'b0});
    send(0, 8'h0F, 1'b1);
    expect_result(0, "f3");
    @(posedge clk); #1;
    @(negedge clk);
    chk_quiet(0, "f3_taken");
    @(posedge clk); #1;

    // Junk with in_valid low must be ignored.
    tv_d[0] = 8'hE7; tv_l[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_quiet(0, "novalid");
    @(posedge clk); #1;

    // Single-beat frames, XOR and XNOR.
    sb_q.push_back('{8'h01, 1'b1, 4'd1, 1'b0});
    send(0, 8'h01, 1'b1);
    expect_result(0, "single");
    @(posedge clk); #1;

    tv_r[1] = 1'b1;
    sb_q.push_back('{8'hC3, 1'b0, 4'd1, 1'b0});
    send(1, 8'h3C, 1'b1);
    expect_result(1, "xnor");
    @(posedge clk); #1;

    // Back-pressure: result held while a word is offered.
    tv_r[0] = 1'b0;
    send(0, 8'h11, 1'b0);
    sb_q.push_back('{8'h33, 1'b0, 4'd2, 1'b0});
    send(0, 8'h22, 1'b1);
    expect_result(0, "hold");
    tv_v[0] = 1'b1; tv_d[0] = 8'h77; tv_l[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      o = sample(0);
      chk("hold_in_ready", o.rdy, 0);
      chk("hold_out_valid", o.vld, 1);
      chk("hold_out_sum", o.sum, 8'h33);
      chk("hold_out_count", o.cnt, 4'd2);
    end
    @(posedge clk); #1;
    tv_r[0] = 1'b1;
    @(negedge clk);
    chk("take_cycle_in_ready", sample(0).rdy, 0);
    @(posedge clk); #1;
    // The word offered during the take cycle must not have been folded in.
    @(negedge clk);
    o = sample(0);
    chk("after_take_out_valid", o.vld, 0);
    chk("after_take_in_ready", o.rdy, 1);
    sb_q.push_back('{8'h77, 1'b0, 4'd1, 1'b0});
    @(posedge clk); #1;
    tv_v[0] = 1'b0; tv_l[0] = 1'b0;
    expect_result(0, "next_word");
    @(posedge clk); #1;

    // Counter saturation and overflow with CW=2.
    tv_r[2] = 1'b1;
    for (int i = 0; i < 4; i++) send(2, 8'h01, 1'b0);
    sb_q.push_back('{8'h01, 1'b1, 4'd3, 1'b1});
    send(2, 8'h01, 1'b1);
    expect_result(2, "sat");
    @(posedge clk); #1;
    @(negedge clk);
    chk_quiet(2, "sat_taken");
    @(posedge clk); #1;

    // Reset aborts a partial frame.
    send(0, 8'hAA, 1'b0);
    send(0, 8'hBB, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_quiet(0, "abort");
    @(posedge clk); #1;
    sb_q.push_back('{8'h80, 1'b1, 4'd1, 1'b0});
    send(0, 8'h80, 1'b1);
    expect_result(0, "post_abort");
    @(posedge clk); #1;

    chk("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/xor_checksum.md
XOR_CHECKSUM -- requirements
Module: xor_checksum

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter CW, default 4, beat-counter width in bits (>=1).
REQ-003 Parameter INVERT, default 0, result mode: 0 = XOR fold, 1 = XNOR fold (final result bitwise inverted).
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 in_valid  input  1  upstream word present.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 in_data  input  WIDTH  word to fold.
REQ-009 in_last  input  1  final word of the frame; qualified by in_valid.
REQ-010 out_valid  output  1  frame result present.
REQ-011 out_ready  input  1  downstream takes the result.
REQ-012 out_sum  output  WIDTH  frame checksum.
REQ-013 out_parity  output  1  XOR-reduction of out_sum.
REQ-014 out_count  output  CW  accepted beats in the frame, saturating.
REQ-015 out_ovf  output  1  frame had more than 2^CW-1 beats.

Function
REQ-016 Input beat accepted iff in_valid and in_ready are both 1 on a rising edge; result taken iff out_valid and out_ready are both 1.
REQ-017 FSM states: IDLE (no beat yet), ACCUM (>=1 beat accepted, no last), DONE (result held).
REQ-018 IDLE: in_ready=1, out_valid=0; accepted beat with in_last=0 -> ACCUM; accepted beat with in_last=1 -> DONE.
REQ-019 ACCUM: in_ready=1, out_valid=0; accepted beat with in_last=1 -> DONE; otherwise stay.
REQ-020 DONE: in_ready=0, out_valid=1; result taken -> IDLE; otherwise stay, all outputs held stable.
REQ-021 No bypass: a word offered while in DONE is not accepted, including in the cycle the result is taken; next accept is earliest one cycle after the result is taken.
REQ-022 Accumulator acc: on the first beat of a frame, acc <= in_data; on each later beat, acc <= acc ^ in_data; acc cleared to 0 on the transition DONE -> IDLE.
REQ-023 out_sum = acc when INVERT=0, ~acc when INVERT=1; out_parity = ^out_sum; both meaningful only when out_valid=1, and held 0 otherwise.
REQ-024 Latency: out_valid asserts on the first cycle after the last beat is accepted.
REQ-025 Beat counter increments per accepted beat and saturates at 2^CW-1; out_ovf set when an accept occurs with the counter already at 2^CW-1, sticky until the frame's result is taken.
REQ-026 Counter and out_ovf cleared on DONE -> IDLE.
REQ-027 in_data and in_last ignored when in_valid=0; in_valid=0 never changes state.
REQ-028 out_count, out_ovf driven 0 whenever out_valid=0.

Reset
REQ-029 rst_n=0 on a rising edge forces state IDLE, acc=0, counter=0, ovf=0 regardless of state, aborting any partial frame or held result without a handshake.
REQ-030 During and on the first cycle after reset: in_ready=1, out_valid=0, out_sum=0, out_parity=0, out_count=0, out_ovf=0.

Verification (WIDTH=8, CW=4, INVERT=0 unless stated)
REQ-031 Beats 0x5A, 0xFF, 0x0F (last), out_ready=1 -> next cycle out_valid=1, out_sum=0xAA, out_parity=0, out_count=3, out_ovf=0; next cycle out_valid=0.
REQ-032 Single beat 0x01 with in_last=1 -> out_sum=0x01, out_parity=1, out_count=1; INVERT=1 with single beat 0x3C -> out_sum=0xC3, out_parity=0.
REQ-033 Result held with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 throughout, outputs unchanged; out_ready=1 -> next cycle out_valid=0, in_ready=1, then the next word is accepted.
REQ-034 CW=2, five beats of 0x01 (fifth last) -> out_count=3, out_ovf=1, out_sum=0x01.
REQ-035 rst_n=0 for one cycle after two beats of a frame -> all outputs at reset values; new frame 0x80 (last) -> out_sum=0x80, out_count=1.
